// File: rtl/sdram_aref.sv
// SDRAM auto-refresh controller. It requests a refresh slot every REF_CNT cycles.
// Once the arbiter grants it, it issues PRECHARGE-ALL followed by two AUTO-REFRESH commands.
module sdram_aref #(
    parameter int unsigned REF_CNT = 750,
    parameter int unsigned TRP_CLK = 2,
    parameter int unsigned TRC_CLK = 7
) (
    input  logic        aref_clk,
    input  logic        aref_rst_n,
    input  logic        init_end,
    input  logic        ar_en,
    output logic        ar_req,
    output logic        ar_end,
    output logic [3:0]  ar_cmd,
    output logic [1:0]  ar_bank,
    output logic [12:0] ar_addr,
    output logic        ar_miss
);

    localparam int unsigned CNT_W    = (REF_CNT > 1) ? $clog2(REF_CNT) : 1;
    localparam int unsigned WAIT_MAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
    localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REF_CNT - 1);
    localparam logic [WAIT_W-1:0] TRP_LAST = WAIT_W'(TRP_CLK - 1);
    localparam logic [WAIT_W-1:0] TRC_LAST = WAIT_W'(TRC_CLK - 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PCH  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        StIdle,
        StPch,
        StTrp,
        StAr1,
        StTrc1,
        StAr2,
        StTrc2,
        StEnd
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_req;
    logic               r_miss;
    logic               r_end;
    logic [3:0]         r_cmd;

    logic               w_term;
    logic               w_leave;
    logic               w_waiting;
    logic [3:0]         w_cmd_nxt;
    logic               w_end_nxt;

    assign w_term  = (r_cnt == CNT_LAST);
    assign w_leave = (r_state == StIdle) && ar_en && r_req;

    // Interval counter free-runs once init is done, including during a sequence.
    always_ff @(posedge aref_clk) begin
        if (!aref_rst_n) begin
            r_cnt <= '0;
        end else if (!init_end) begin
            r_cnt <= '0;
        end else if (w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A new terminal beats the clear on the IDLE-exit edge, so back-to-back intervals are not lost.
    always_ff @(posedge aref_clk) begin
        if (!aref_rst_n) begin
            r_req  <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            if (w_term) begin
                r_req <= 1'b1;
            end else if (w_leave) begin
                r_req <= 1'b0;
            end
            if (w_term && r_req && !w_leave) begin
                r_miss <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (ar_en && r_req) w_state_nxt = StPch;
            StPch:   w_state_nxt = StTrp;
            StTrp:   if (r_wait == TRP_LAST) w_state_nxt = StAr1;
            StAr1:   w_state_nxt = StTrc1;
            StTrc1:  if (r_wait == TRC_LAST) w_state_nxt = StAr2;
            StAr2:   w_state_nxt = StTrc2;
            StTrc2:  if (r_wait == TRC_LAST) w_state_nxt = StEnd;
            StEnd:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_waiting = (r_state == StTrp) || (r_state == StTrc1) || (r_state == StTrc2);

    always_ff @(posedge aref_clk) begin
        if (!aref_rst_n) begin
            r_state <= StIdle;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_wait <= '0;
            end else if (w_waiting) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    // Commands are decoded from the current state and registered, lagging the state by one cycle.
    always_comb begin
        w_cmd_nxt = CMD_NOP;
        w_end_nxt = 1'b0;
        case (r_state)
            StPch:         w_cmd_nxt = CMD_PCH;
            StAr1, StAr2:  w_cmd_nxt = CMD_AREF;
            StEnd:         w_end_nxt = 1'b1;
            default:       w_cmd_nxt = CMD_NOP;
        endcase
    end

    always_ff @(posedge aref_clk) begin
        if (!aref_rst_n) begin
            r_cmd <= CMD_NOP;
            r_end <= 1'b0;
        end else begin
            r_cmd <= w_cmd_nxt;
            r_end <= w_end_nxt;
        end
    end

    assign ar_req  = r_req;
    assign ar_end  = r_end;
    assign ar_cmd  = r_cmd;
    assign ar_miss = r_miss;
    assign ar_bank = 2'b11;
    assign ar_addr = 13'h1fff;

endmodule

// File: tb/tb_sdram_aref.sv
// Directed and random stimulus for sdram_aref. The DUT is checked against a sequence-offset
// model of the refresh timing.
module tb_sdram_aref;

    localparam int REF = 50;
    localparam int TRP = 2;
    localparam int TRC = 7;
    localparam int OFF_PCH = 1;
    localparam int OFF_AR1 = 2 + TRP;
    localparam int OFF_AR2 = 3 + TRP + TRC;
    localparam int OFF_END = 4 + TRP + 2 * TRC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_end = 1'b0;
    logic        ar_en = 1'b0;
    logic        ar_req;
    logic        ar_end;
    logic [3:0]  ar_cmd;
    logic [1:0]  ar_bank;
    logic [12:0] ar_addr;
    logic        ar_miss;

    int checks = 0;
    int errors = 0;

    // Model: interval count, pending/miss flags, and cycles since the IDLE-exit edge (-1 = none).
    int m_cnt = 0;
    bit m_req = 1'b0;
    bit m_miss = 1'b0;
    int m_off = -1;

    sdram_aref #(
        .REF_CNT (REF),
        .TRP_CLK (TRP),
        .TRC_CLK (TRC)
    ) u_dut (
        .aref_clk   (clk),
        .aref_rst_n (rst_n),
        .init_end   (init_end),
        .ar_en      (ar_en),
        .ar_req     (ar_req),
        .ar_end     (ar_end),
        .ar_cmd     (ar_cmd),
        .ar_bank    (ar_bank),
        .ar_addr    (ar_addr),
        .ar_miss    (ar_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(input bit rst, input bit ie, input bit en);
        bit term;
        bit idle;
        bit leave;
        if (!rst) begin
            m_cnt = 0;
            m_req = 1'b0;
            m_miss = 1'b0;
            m_off = -1;
            return;
        end
        term  = (m_cnt == REF - 1);
        idle  = (m_off < 0) || (m_off >= OFF_END);
        leave = idle && en && m_req;
        if (term && m_req && !leave) m_miss = 1'b1;
        if (term) m_req = 1'b1;
        else if (leave) m_req = 1'b0;
        m_cnt = ie ? (m_cnt + 1) % REF : 0;
        if (leave) m_off = 0;
        else if (!idle) m_off = m_off + 1;
        else m_off = -1;
    endfunction

    task automatic check_outputs();
        logic [3:0] exp_cmd;
        if (m_off == OFF_PCH) exp_cmd = 4'b0010;
        else if (m_off == OFF_AR1 || m_off == OFF_AR2) exp_cmd = 4'b0001;
        else exp_cmd = 4'b0111;
        chk("ar_req", 32'(ar_req), 32'(m_req));
        chk("ar_miss", 32'(ar_miss), 32'(m_miss));
        chk("ar_end", 32'(ar_end), 32'(m_off == OFF_END));
        chk("ar_cmd", 32'(ar_cmd), 32'(exp_cmd));
        chk("ar_bank", 32'(ar_bank), 32'h3);
        chk("ar_addr", 32'(ar_addr), 32'h1fff);
        chk("ref_cnt", 32'(u_dut.r_cnt), 32'(m_cnt));
    endtask

    task automatic step(input bit rst, input bit ie, input bit en);
        @(negedge clk);
        rst_n = rst;
        init_end = ie;
        ar_en = en;
        @(posedge clk);
        model_edge(rst, ie, en);
        #1;
        check_outputs();
    endtask

    // en_mode: 0 low, 1 high, 2 tied to pending request, 3 random
    task automatic run(input int n, input bit ie, input int en_mode);
        bit en;
        for (int i = 0; i < n; i++) begin
            case (en_mode)
                0: en = 1'b0;
                1: en = 1'b1;
                2: en = m_req;
                default: en = 1'($urandom_range(0, 1));
            endcase
            step(1'b1, ie, en);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Run with ar_en tied to the request until the model reaches the given sequence offset.
    task automatic run_to_offset(input int off, input string tag);
        int budget;
        budget = 0;
        while (m_off != off && budget < 200) begin
            step(1'b1, 1'b1, m_req);
            budget++;
        end
        chk(tag, 32'(m_off == off), 32'd1);
    endtask

    initial begin
        int budget;
        bit rnd_ie;

        // Reset values
        do_reset();
        chk("rst_req", 32'(ar_req), 32'd0);
        chk("rst_cmd", 32'(ar_cmd), 32'h7);

        // Request after REF cycles, miss one cycle after the next terminal
        for (int i = 1; i <= 101; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i == 49) chk("req_before_50", 32'(ar_req), 32'd0);
            if (i == 50) chk("req_at_50", 32'(ar_req), 32'd1);
            if (i == 99) chk("miss_before_100", 32'(ar_miss), 32'd0);
            if (i == 100) chk("miss_at_100", 32'(ar_miss), 32'd1);
        end

        // init_end held low: counter frozen, no request
        do_reset();
        run(1000, 1'b0, 3);
        chk("noinit_req", 32'(ar_req), 32'd0);
        chk("noinit_cnt", 32'(u_dut.r_cnt), 32'd0);

        // Full sequence with ar_en tied to ar_req
        do_reset();
        run(120, 1'b1, 2);

        // Grant withdrawn at offset 6: sequence still completes
        do_reset();
        run_to_offset(6, "reach_off6");
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (m_off == OFF_AR2) chk("ar2_after_drop", 32'(ar_cmd), 32'h1);
            if (m_off == OFF_END) chk("end_after_drop", 32'(ar_end), 32'd1);
        end

        // Reset at offset 8 aborts the sequence
        do_reset();
        run_to_offset(7, "reach_off7");
        step(1'b0, 1'b1, 1'b1);
        chk("abort_cmd", 32'(ar_cmd), 32'h7);
        chk("abort_end", 32'(ar_end), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("abort_no_cmd", 32'(ar_cmd), 32'h7);
        end

        // Terminal coinciding with IDLE exit: request stays set, no miss
        do_reset();
        budget = 0;
        while (!(m_req && m_cnt == REF - 1) && budget < 300) begin
            step(1'b1, 1'b1, 1'b0);
            budget++;
        end
        chk("reach_coincide", 32'(m_req && m_cnt == REF - 1), 32'd1);
        step(1'b1, 1'b1, 1'b1);
        chk("coincide_req", 32'(ar_req), 32'd1);
        chk("coincide_miss", 32'(ar_miss), 32'd0);
        run(60, 1'b1, 2);

        // Random traffic with occasional reset and init_end toggling
        do_reset();
        rnd_ie = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) rnd_ie = ~rnd_ie;
            step(($urandom_range(0, 299) != 0), rnd_ie, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
